// File: rtl/seq_nonrestoring_divider.sv
// Iterative non-restoring divider: one quotient bit per clock, then one remainder-fix cycle.
// Define NRDIV_SIGNED_EN for two's-complement operands (adds a SIGN state, +1 cycle latency).
module seq_nonrestoring_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder,
  output logic          o_dbz,
  output logic          o_busy
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

`ifdef NRDIV_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_SIGN, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`endif

  state_t        r_state, w_next;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_v;
  logic [VW:0]   r_p;
  logic [DW-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic          r_zero;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_dbz;
`ifdef NRDIV_SIGNED_EN
  logic          r_negQ;
  logic          r_negR;
`endif

  logic          w_accept;
  logic          w_divZero;
  logic [DW-1:0] w_dvdMag;
  logic [VW-1:0] w_dvsMag;
  logic [VW:0]   w_vext;
  logic [VW:0]   w_a;
  logic [VW:0]   w_sum;
  logic [VW-1:0] w_rem;

  assign o_in_ready  = (r_state == S_IDLE) & ~i_rst;
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_dbz       = r_dbz;

  assign w_accept  = i_in_valid & o_in_ready;
  assign w_divZero = (i_divisor == '0);

`ifdef NRDIV_SIGNED_EN
  assign w_dvdMag = i_dividend[DW-1] ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dvsMag = i_divisor[VW-1]  ? (~i_divisor + 1'b1)  : i_divisor;
`else
  assign w_dvdMag = i_dividend;
  assign w_dvsMag = i_divisor;
`endif

  // One shared adder: RUN feeds 2P+b, FIX feeds P; the sign of P picks add or subtract.
  // P wraps modulo 2^(VW+1) inside RUN, but each result lands back in [-V, V).
  assign w_vext = {1'b0, r_v};
  assign w_a    = (r_state == S_FIX) ? r_p : {r_p[VW-1:0], r_dvd[DW-1]};
  assign w_sum  = r_p[VW] ? (w_a + w_vext) : (w_a - w_vext);
  assign w_rem  = r_p[VW] ? w_sum[VW-1:0] : r_p[VW-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_divZero ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
`ifdef NRDIV_SIGNED_EN
      S_FIX:  w_next = r_zero ? S_DONE : S_SIGN;
      S_SIGN: w_next = S_DONE;
`else
      S_FIX:  w_next = S_DONE;
`endif
      S_DONE: if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_v     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef NRDIV_SIGNED_EN
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // A zero divisor skips RUN; the raw dividend is kept for the remainder.
            r_dvd  <= w_divZero ? i_dividend : w_dvdMag;
            r_v    <= w_dvsMag;
            r_p    <= '0;
            r_q    <= '0;
            r_cnt  <= CW'(DW - 1);
            r_zero <= w_divZero;
`ifdef NRDIV_SIGNED_EN
            r_negQ <= i_dividend[DW-1] ^ i_divisor[VW-1];
            r_negR <= i_dividend[DW-1];
`endif
          end
        end
        S_RUN: begin
          r_p   <= w_sum;
          r_q   <= {r_q[DW-2:0], ~w_sum[VW]};
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (r_zero) begin
            r_quot <= '1;
            r_rem  <= r_dvd[VW-1:0];
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= r_q;
            r_rem  <= w_rem;
            r_dbz  <= 1'b0;
          end
        end
`ifdef NRDIV_SIGNED_EN
        S_SIGN: begin
          if (r_negQ) r_quot <= ~r_quot + 1'b1;
          if (r_negR) r_rem  <= ~r_rem + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
